// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the core (port 0) and the
// UART loader (port 1). One access in flight; reads and writes take a uniform L-cycle wait.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_ready,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_ready,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-3:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                owner
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t              state;
   logic                last;
   logic                txn_we;
   logic [2:0]          wait_cnt;

   logic                grant_vld;
   logic                grant_port;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_wstrb;

   // Word-aligned RAM: the byte offset bits carry no information here.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

   always_comb begin
      grant_vld  = m0_req | m1_req;
      grant_port = (m0_req & m1_req) ? ~last : m1_req;
      sel_we     = grant_port ? m1_we    : m0_we;
      sel_addr   = grant_port ? m1_addr  : m0_addr;
      sel_wdata  = grant_port ? m1_wdata : m0_wdata;
      sel_wstrb  = grant_port ? m1_wstrb : m0_wstrb;
   end

   // The mem_* registers double as the latched request: they are loaded on grant,
   // presented for the single ACCESS cycle and cleared afterwards.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         busy      <= 1'b0;
         txn_we    <= 1'b0;
         wait_cnt  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  owner     <= grant_port;
                  txn_we    <= sel_we;
                  busy      <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_addr  <= sel_addr[ADDR_W-1:2];
                  mem_we    <= sel_we ? sel_wstrb : '0;
                  mem_wdata <= sel_we ? sel_wdata : '0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               wait_cnt <= 3'(MEM_LATENCY);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == 3'd1) begin
                  if (!txn_we) begin
                     if (owner) m1_rdata <= mem_rdata;
                     else       m0_rdata <= mem_rdata;
                  end
                  m0_ready <= ~owner;
                  m1_ready <= owner;
                  state    <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RESP: begin
               last  <= owner;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle under
// random two-port traffic, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

   localparam int L = 1;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  req_v, we_v;
   logic [31:0] addr_v [2];
   logic [31:0] wdata_v [2];
   logic [3:0]  strb_v [2];
   logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
   logic        m0_ready, m1_ready, mem_en, busy, owner;
   logic [3:0]  mem_we;
   logic [29:0] mem_addr;

   logic        u3_req, u3_mem_en, u3_busy, u3_owner, u3_m0_ready, u3_m1_ready;
   logic [31:0] u3_addr, u3_m0_rdata, u3_m1_rdata, u3_mem_wdata, u3_mem_rdata;
   logic [3:0]  u3_mem_we;
   logic [29:0] u3_mem_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
      .m0_wstrb(strb_v[0]), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
      .m1_wstrb(strb_v[1]), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u3 (
      .clk(clk), .resetn(resetn),
      .m0_req(u3_req), .m0_we(1'b0), .m0_addr(u3_addr), .m0_wdata(32'h0),
      .m0_wstrb(4'h0), .m0_rdata(u3_m0_rdata), .m0_ready(u3_m0_ready),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
      .m1_wstrb(4'h0), .m1_rdata(u3_m1_rdata), .m1_ready(u3_m1_ready),
      .mem_en(u3_mem_en), .mem_we(u3_mem_we), .mem_addr(u3_mem_addr),
      .mem_wdata(u3_mem_wdata), .mem_rdata(u3_mem_rdata), .busy(u3_busy), .owner(u3_owner));

   // RAMs drive garbage outside the single cycle their read data is valid.
   logic [31:0] ram0 [64];
   logic [31:0] ram3 [64];
   logic        rd0_v;
   logic [31:0] rd0_d;
   logic [2:0]  rd3_v;
   logic [31:0] rd3_d [3];

   always @(posedge clk) begin
      rd0_v <= mem_en;
      rd0_d <= ram0[mem_addr[5:0]];
      if (mem_en)
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram0[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      rd3_v    <= {rd3_v[1:0], u3_mem_en};
      rd3_d[0] <= ram3[u3_mem_addr[5:0]];
      rd3_d[1] <= rd3_d[0];
      rd3_d[2] <= rd3_d[1];
   end
   assign mem_rdata    = rd0_v    ? rd0_d    : 32'hBADC0DE5;
   assign u3_mem_rdata = rd3_v[2] ? rd3_d[2] : 32'hBADC0DE5;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: one transaction at a time, outputs derived from the grant cycle.
   logic [31:0] mdl_mem [64];
   int          c = 0;
   int          c0 = 0;
   bit          act = 0;
   bit          m_last = 1;
   bit          m_owner = 0;
   logic [31:0] exp_rd [2];
   bit          t_port, t_we;
   logic [31:0] t_addr, t_wdata, t_rval;
   logic [3:0]  t_strb;

   always @(negedge clk) begin : cmp
      int         rel;
      bit         e_en, e_busy, e_rdy0, e_rdy1;
      logic [5:0] w;
      rel = c - c0;
      if (!resetn) begin
         act = 0; m_last = 1; m_owner = 0;
         exp_rd[0] = '0; exp_rd[1] = '0;
      end else if (act && rel == 2 + L && !t_we) begin
         exp_rd[t_port] = t_rval;
      end
      e_busy = act && rel >= 1 && rel <= 2 + L;
      e_en   = act && rel == 1;
      e_rdy0 = act && rel == 2 + L && !t_port;
      e_rdy1 = act && rel == 2 + L && t_port;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_addr", 32'(mem_addr), e_en ? 32'(t_addr[31:2]) : 32'h0);
      chk("mem_we", 32'(mem_we), (e_en && t_we) ? 32'(t_strb) : 32'h0);
      if (!e_en || t_we) chk("mem_wdata", mem_wdata, e_en ? t_wdata : 32'h0);
      chk("m0_ready", 32'(m0_ready), 32'(e_rdy0));
      chk("m1_ready", 32'(m1_ready), 32'(e_rdy1));
      chk("m0_rdata", m0_rdata, exp_rd[0]);
      chk("m1_rdata", m1_rdata, exp_rd[1]);
      chk("owner", 32'(owner), 32'(m_owner));
      if (resetn) begin
         if (act && rel == 1) begin
            w = t_addr[7:2];
            t_rval = mdl_mem[w];
            if (t_we)
               for (int b = 0; b < 4; b++)
                  if (t_strb[b]) mdl_mem[w][8*b +: 8] = t_wdata[8*b +: 8];
         end
         if (act && rel == 2 + L) m_last = t_port;
         if (act && rel >= 3 + L) act = 0;
         if (!act && (req_v[0] || req_v[1])) begin
            t_port  = (req_v[0] && req_v[1]) ? ~m_last : req_v[1];
            t_we    = we_v[t_port];
            t_addr  = addr_v[t_port];
            t_wdata = wdata_v[t_port];
            t_strb  = strb_v[t_port];
            act = 1; c0 = c; m_owner = t_port;
         end
      end
      c++;
   end

   int          r_en_c, r_rdy_c;
   logic [31:0] r_rdata, r_wdata;
   logic [29:0] r_addr;
   logic [3:0]  r_we;

   // Single transaction from idle; req held until the IDLE cycle after ready.
   task automatic one_txn(input int p, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = d; strb_v[p] = s;
      r_en_c = -1; r_rdy_c = -1;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) req_v[p] = 1'b0;
         @(negedge clk);
         if (mem_en && r_en_c < 0) begin
            r_en_c = k; r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata;
         end
         if ((p == 0 ? m0_ready : m1_ready) && r_rdy_c < 0) begin
            r_rdy_c = k; r_rdata = (p == 0) ? m0_rdata : m1_rdata;
         end
         tick;
      end
   endtask

   task automatic new_txn(input int p);
      req_v[p]   = 1'b1;
      we_v[p]    = 1'($urandom_range(1));
      addr_v[p]  = {24'd0, 6'($urandom_range(63)), 2'($urandom_range(3))};
      wdata_v[p] = $urandom;
      strb_v[p]  = 4'($urandom_range(15));
   endtask

   task automatic agent(input int p, input bit rdy);
      int r;
      if (rdy) begin
         if ($urandom_range(1) == 1) new_txn(p);
         else req_v[p] = 1'b0;
      end else if (!req_v[p]) begin
         if ($urandom_range(2) == 0) new_txn(p);
      end else begin
         r = $urandom_range(15);
         if (r == 0) req_v[p] = 1'b0;
         else if (r < 3) new_txn(p);
      end
   endtask

   initial begin
      int          en_c, rdy_c, pulses, coinc;
      logic [31:0] d;
      logic [29:0] a;
      int          en_q[$];
      int          ord_q[$];
      bit          rdy0, rdy1;

      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         ram0[i] = d; mdl_mem[i] = d;
         ram3[i] = $urandom;
      end
      ram0[16] = 32'hDEADBEEF; mdl_mem[16] = 32'hDEADBEEF; ram3[16] = 32'h13579BDF;

      // Reset held with both ports requesting.
      resetn = 1'b0; req_v = 2'b11; we_v = 2'b00;
      for (int p = 0; p < 2; p++) begin
         addr_v[p] = 32'h40; wdata_v[p] = 32'h0; strb_v[p] = 4'h0;
      end
      u3_req = 1'b1; u3_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_mem_en", 32'(mem_en), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_owner", 32'(owner), 32'h0);
         chk("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
         chk("rst_u3_mem_en", 32'(u3_mem_en), 32'h0);
      end
      tick;
      resetn = 1'b1; req_v = 2'b00; u3_req = 1'b0;

      // Latency 3 instance: read of word 0x10.
      tick;
      u3_req = 1'b1; u3_addr = 32'h40;
      en_c = -1; rdy_c = -1; pulses = 0; d = '0; a = '0;
      for (int k = 0; k < 9; k++) begin
         if (k == 1) u3_req = 1'b0;
         @(negedge clk);
         if (u3_mem_en && en_c < 0) begin en_c = k; a = u3_mem_addr; end
         if (u3_m0_ready) begin
            pulses++;
            if (rdy_c < 0) begin rdy_c = k; d = u3_m0_rdata; end
         end
         tick;
      end
      chk("l3_en_cycle", 32'(en_c), 32'd1);
      chk("l3_mem_addr", 32'(a), 32'h10);
      chk("l3_ready_cycle", 32'(rdy_c), 32'd5);
      chk("l3_rdata", d, 32'h13579BDF);
      chk("l3_pulses", 32'(pulses), 32'd1);

      // Single core read.
      one_txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
      chk("rd_en_cycle", 32'(r_en_c), 32'd1);
      chk("rd_mem_addr", 32'(r_addr), 32'h10);
      chk("rd_ready_cycle", 32'(r_rdy_c), 32'd3);
      chk("rd_rdata", r_rdata, 32'hDEADBEEF);

      // Round-robin with both ports requesting continuously from a fresh reset.
      resetn = 1'b0;
      tick;
      resetn = 1'b1;
      req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'h80; addr_v[1] = 32'hC4;
      coinc = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (mem_en) en_q.push_back(k);
         if (m0_ready && m1_ready) coinc++;
         if (m0_ready) ord_q.push_back(0);
         if (m1_ready) ord_q.push_back(1);
         tick;
      end
      req_v = 2'b00;
      chk("rr_grants", 32'(ord_q.size()), 32'd4);
      chk("rr_en_count", 32'(en_q.size()), 32'd4);
      chk("rr_coincident", 32'(coinc), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i < ord_q.size()) chk("rr_order", 32'(ord_q[i]), 32'(i % 2));
         if (i < en_q.size()) chk("rr_en_cycle", 32'(en_q[i]), 32'(1 + 4 * i));
      end
      repeat (3) tick;

      // Loader byte write, then core readback.
      one_txn(1, 1'b1, 32'h41, 32'h000000AA, 4'b0001);
      chk("bw_mem_we", 32'(r_we), 32'h1);
      chk("bw_mem_addr", 32'(r_addr), 32'h10);
      chk("bw_mem_wdata", r_wdata, 32'h000000AA);
      chk("bw_ready_cycle", 32'(r_rdy_c), 32'd3);
      one_txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
      chk("bw_readback", r_rdata, 32'hDEADBEAA);

      // Reset during WAIT abandons the access.
      req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h40;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin resetn = 1'b0; req_v[0] = 1'b0; end
         if (k == 4) resetn = 1'b1;
         @(negedge clk);
         if (k == 2) begin
            chk("mid_rst_busy", 32'(busy), 32'h0);
            chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
            chk("mid_rst_m0_rdata", m0_rdata, 32'h0);
         end
         if (k >= 2 && (m0_ready || m1_ready)) pulses++;
         tick;
      end
      chk("mid_rst_no_ready", 32'(pulses), 32'd0);
      one_txn(0, 1'b0, 32'h40, 32'h0, 4'h0);
      chk("after_rst_ready_cycle", 32'(r_rdy_c), 32'd3);
      chk("after_rst_rdata", r_rdata, 32'hDEADBEAA);

      // Random two-port traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rdy0 = m0_ready; rdy1 = m1_ready;
         agent(0, rdy0);
         agent(1, rdy1);
         tick;
      end
      req_v = 2'b00;
      repeat (10) tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified RAM between the multi-cycle RISC-V core (port 0) and the FTDI UART loader/debug engine (port 1). Each requester uses a req/ready handshake. The arbiter grants one access at a time round-robin, sequences the RAM enable, write strobes and read-latency wait, and returns registered read data. It sits inside `top` between the core/loader and the RAM.

## Interface
- `ADDR_W`, 32: byte address width of both requester ports.
- `DATA_W`, 32: data width; fixed to 32, so there are 4 byte strobes.
- `MEM_LATENCY`, 1: RAM cycles from the `mem_en` sampling edge to valid `mem_rdata`; legal range 1..4.

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `m0_req` in 1: core request, held high until `m0_ready`.
- `m0_we` in 1: 1 = write, 0 = read.
- `m0_addr` in ADDR_W: byte address; bits [1:0] are ignored.
- `m0_wdata` in 32: write data.
- `m0_wstrb` in 4: byte enables; ignored on reads.
- `m0_rdata` out 32: read data, valid while `m0_ready` is high.
- `m0_ready` out 1: one-cycle completion pulse.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_rdata`, `m1_ready`: loader port, identical to port 0.
- `mem_en` out 1: RAM access strobe, high for exactly one cycle per access.
- `mem_we` out 4: RAM byte write enables.
- `mem_addr` out ADDR_W-2: word address, equal to `addr[ADDR_W-1:2]`.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 1: port currently or last granted.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one port has `req` high, grant that port.
  - If both are high, grant the port not equal to `last`. `last` resets to 1, so the core wins the first tie.
  - On grant, latch `owner`, the address, `we`, `wdata` and `wstrb` into registers, then go to ACCESS.
- **ACCESS (1 cycle):**
  - `mem_en` = 1 and `mem_addr` comes from the latched address.
  - For a write, `mem_we` = latched `wstrb` and `mem_wdata` = latched data.
  - For a read, `mem_we` = 0.
  - Load the wait counter with MEM_LATENCY and go to WAIT.
- **WAIT:**
  - The counter decrements each cycle.
  - In the cycle where it reaches 1, capture `mem_rdata` into the response register and go to RESP.
  - Writes wait the same number of cycles, for uniform timing.
- **RESP (1 cycle):**
  - Pulse `mX_ready` for the owner only.
  - The owner's `mX_rdata` shows the captured word; on writes it shows the previous captured value.
  - Set `last` = `owner`, then go to IDLE.
- Non-owner ready stays 0. The non-owner's `rdata` holds its last value.
- All `mem_*` outputs are 0 outside ACCESS.
- Requester inputs are only sampled in IDLE; changes during a transaction are ignored.
- A write with `wstrb` = 0 still completes normally, with `mem_en` = 1 and `mem_we` = 0.
- If a requester drops `req` before ready, the transaction still completes and ready still pulses.
- If `req` is still high in the IDLE cycle after RESP, it is treated as a new request.

## Timing
- Reset (asynchronous, while `resetn` = 0):
  - State = IDLE, `last` = 1.
  - `owner`, `busy`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both ready and both rdata = 0.
- Reset mid-transaction abandons the access immediately; no ready pulse follows.
- With `req` sampled in IDLE in cycle 0:
  - ACCESS in cycle 1.
  - WAIT in cycles 2..1+L, where L = MEM_LATENCY.
  - Ready in cycle 2+L.
- Minimum period between grants is 3+L cycles. With L = 1 that is ready in cycle 3, next grant in cycle 4.
- Round-robin guarantees that a continuously requesting port waits at most one other transaction.

## Test plan
1. **Reset values:** hold `resetn` = 0 for 3 cycles with both `req` = 1 -> all outputs 0 and `mem_en` never asserted.
2. **Single read:** RAM word 0x10 = 0xDEADBEEF, core read of addr 0x40, L = 1 -> `mem_en` in cycle 1 with `mem_addr` = 0x10, `m0_ready` in cycle 3 with `m0_rdata` = 0xDEADBEEF.
3. **Round-robin:** both ports hold `req` for 4 transactions -> grant order 0,1,0,1, `mem_en` spacing 4 cycles, `m1_ready` never coincident with `m0_ready`.
4. **Byte write:** loader writes 0x000000AA with `wstrb` = 0001 to addr 0x41 -> `mem_we` = 0001, `mem_addr` = 0x10, readback 0xDEADBEAA.
5. **Reset mid-access:** drop `resetn` during WAIT -> all outputs 0 that same cycle, no ready pulse, next request served normally.
6. **Longer latency:** MEM_LATENCY = 3, core read -> ready in cycle 5, data captured from the RAM in cycle 4.
